// File: rtl/spi_cfg_sequencer.sv
// Write-only SPI master: queued {addr,data} requests go out as 16-bit mode-0 frames (R/W=1, MSB first).
// Optional `define SPI_CFG_ADDR_CHECK_EN drops requests with addr > MAX_ADDR and pulses o_err instead.
module spi_cfg_sequencer #(
   parameter int CLK_DIV  = 4,
   parameter int CS_GAP   = 8,
   parameter int DEPTH    = 4,
   parameter int MAX_ADDR = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_req_valid,
   output logic       o_req_ready,
   input  logic [6:0] i_req_addr,
   input  logic [7:0] i_req_data,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_err,
   output logic       o_sclk,
   output logic       o_copi,
   output logic       o_ncs
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [7:0]    GAP_LAST = 8'(CS_GAP - 1);
   localparam logic [PW:0]   FULL     = (PW+1)'(DEPTH);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
`ifdef SPI_CFG_ADDR_CHECK_EN
   localparam bit ADDR_CHECK = 1'b1;
`else
   localparam bit ADDR_CHECK = 1'b0;
`endif

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

   state_t        r_state;
   logic [14:0]   r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;
   logic [15:0]   r_shift;
   logic [7:0]    r_cnt;
   logic [4:0]    r_edge_cnt;
   logic          r_sclk;
   logic          r_copi;
   logic          r_ncs;
   logic          r_done;
   logic          r_err;
   logic          w_accept;
   logic          w_addr_bad;
   logic          w_push;
   logic          w_pop;

   assign o_req_ready = (r_count != FULL);
   assign w_accept    = i_req_valid && o_req_ready;
   assign w_addr_bad  = ADDR_CHECK && ({25'd0, i_req_addr} > 32'(MAX_ADDR));
   assign w_push      = w_accept && !w_addr_bad;
   assign w_pop       = (r_state == S_IDLE) && (r_count != '0);

   assign o_busy = (r_count != '0) || (r_state != S_IDLE);
   assign o_done = r_done;
   assign o_err  = r_err;
   assign o_sclk = r_sclk;
   assign o_copi = r_copi;
   assign o_ncs  = r_ncs;

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {i_req_addr, i_req_data};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
         r_err <= w_accept && w_addr_bad;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_cnt      <= '0;
         r_edge_cnt <= '0;
         r_sclk     <= 1'b0;
         r_copi     <= 1'b0;
         r_ncs      <= 1'b1;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_shift <= {1'b1, r_mem[r_rd_ptr]};
                  r_ncs   <= 1'b0;
                  r_copi  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_SETUP;
               end
            end
            S_SETUP: begin
               if (r_cnt == DIV_LAST) begin
                  r_cnt      <= '0;
                  r_sclk     <= 1'b1;
                  r_edge_cnt <= 5'd1;
                  r_state    <= S_SHIFT;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_SHIFT: begin
               if (r_cnt == DIV_LAST) begin
                  r_cnt      <= '0;
                  r_sclk     <= !r_sclk;
                  r_edge_cnt <= r_edge_cnt + 5'd1;
                  // COPI only moves on falling edges; edge 32 is the 16th falling edge.
                  if (r_sclk) begin
                     r_shift <= {r_shift[14:0], 1'b0};
                     r_copi  <= r_shift[14];
                     if (r_edge_cnt == 5'd31) begin
                        r_copi  <= 1'b0;
                        r_state <= S_HOLD;
                     end
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_HOLD: begin
               if (r_cnt == DIV_LAST) begin
                  r_cnt   <= '0;
                  r_ncs   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= S_GAP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_GAP: begin
               if (r_cnt == GAP_LAST) begin
                  r_cnt   <= '0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Scoreboard bench for spi_cfg_sequencer: two instances (CLK_DIV 4 and 2) driven with directed and random writes.
`timescale 1ns/1ps
module tb_spi_cfg_sequencer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input int inst, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL [%0d] %s: got 0x%0h, expected 0x%0h at %0t", inst, name, act, exp, $time);
      end
   endtask

   for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int CD   = (gi == 0) ? 4 : 2;
      localparam int GAP  = (gi == 0) ? 8 : 3;
      localparam int DEP  = 4;
      localparam int MAXA = 4;
      localparam logic [6:0] FA = (gi == 0) ? 7'h00 : 7'h04;
      localparam logic [7:0] FD = (gi == 0) ? 8'hA5 : 8'h80;

      logic       rst_n, valid, ready, busy, done, err, sclk, copi, ncs;
      logic [6:0] addr;
      logic [7:0] data;
      logic [14:0] exp_q [$];
      logic [7:0] periph_regs [128];
      logic [7:0] exp_regs [128];
      int n_enq = 0, n_started = 0, err_pend = 0, n_done = 0;
      int cyc = 0, fall_cyc = 0, nbits = 0;
      bit fin = 1'b0;

      spi_cfg_sequencer #(.CLK_DIV(CD), .CS_GAP(GAP), .DEPTH(DEP), .MAX_ADDR(MAXA)) u_dut (
         .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(valid), .o_req_ready(ready),
         .i_req_addr(addr), .i_req_data(data), .o_busy(busy), .o_done(done), .o_err(err),
         .o_sclk(sclk), .o_copi(copi), .o_ncs(ncs)
      );

      // Peripheral + scoreboard: decodes frames from the pins and compares with the expected queue.
      initial begin : monitor
         logic p_ncs, p_sclk, p_copi;
         logic [15:0] bits;
         logic [14:0] e;
         int prev_fall, since_rise, occ;
         bit have_prev;
         p_ncs = 1'b1; p_sclk = 1'b0; p_copi = 1'b0; bits = '0;
         prev_fall = 0; since_rise = 1000; have_prev = 1'b0;
         for (int a = 0; a < 128; a++) begin
            periph_regs[a] = 8'h00;
            exp_regs[a]    = 8'h00;
         end
         forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
               have_prev = 1'b0; since_rise = 1000; nbits = 0;
            end else begin
               if (p_ncs && !ncs) begin
                  if (have_prev) check(gi, "cs gap fall-to-fall", (cyc - prev_fall) >= (33*CD + GAP + 1), 1);
                  have_prev = 1'b1; prev_fall = cyc; fall_cyc = cyc; n_started++; nbits = 0;
               end
               if (!ncs && sclk && !p_sclk) begin
                  nbits++;
                  bits = {bits[14:0], copi};
                  check(gi, "sclk rise time", cyc - fall_cyc, (2*nbits - 1)*CD);
               end
               if (sclk) check(gi, "copi stable while sclk high", copi, p_copi);
               if (ncs) check(gi, "sclk idle low", sclk, 0);
               if (!p_ncs && ncs) begin
                  check(gi, "ncs low cycles", cyc - fall_cyc, 33*CD);
                  check(gi, "rising edges per frame", nbits, 16);
                  check(gi, "done with ncs rise", done, 1);
                  n_done++;
                  if (nbits == 16) periph_regs[bits[14:8]] = bits[7:0];
                  check(gi, "frame was expected", exp_q.size() > 0, 1);
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     check(gi, "frame bits", bits, {1'b1, e});
                     exp_regs[e[14:8]] = e[7:0];
                  end
                  nbits = 0;
                  since_rise = 0;
               end else begin
                  check(gi, "no stray done", done, 0);
                  if (since_rise < 1000) since_rise++;
               end
               if (err) begin
                  check(gi, "err pulse expected", err_pend > 0, 1);
                  if (err_pend > 0) err_pend--;
               end
               occ = n_enq - n_started;
               check(gi, "req_ready", ready, occ < DEP);
               check(gi, "busy", busy, (occ > 0) || !ncs || (since_rise < GAP));
            end
            p_ncs = ncs; p_sclk = sclk; p_copi = copi;
         end
      end

      task automatic push(input logic [6:0] a, input logic [7:0] d, output int nwait);
         bit acc, legal;
         nwait = 0; acc = 1'b0;
         valid = 1'b1; addr = a; data = d;
`ifdef SPI_CFG_ADDR_CHECK_EN
         legal = (a <= 7'(MAXA));
`else
         legal = 1'b1;
`endif
         while (!acc && nwait < 3000) begin
            @(negedge clk);
            acc = ready;
            @(posedge clk); #1;
            if (!acc) nwait++;
         end
         valid = 1'b0;
         if (!acc) check(gi, "push accepted", acc, 1);
         else if (legal) begin
            exp_q.push_back({a, d});
            n_enq++;
         end else err_pend++;
      endtask

      task automatic wait_idle();
         int n = 0;
         while ((busy || exp_q.size() != 0) && n < 6000) begin
            @(posedge clk); #1;
            n++;
         end
         check(gi, "drained before timeout", n < 6000, 1);
         repeat (2) begin @(posedge clk); #1; end
      endtask

      initial begin : stim
         int nw, st, acc_cyc, dn0, n, bad;
         logic [7:0] d;
         logic [7:0] snap [128];
         rst_n = 1'b0; valid = 1'b0; addr = '0; data = '0;
         repeat (3) @(posedge clk);
         #1;
         check(gi, "reset ncs", ncs, 1);
         check(gi, "reset sclk", sclk, 0);
         check(gi, "reset copi", copi, 0);
         check(gi, "reset done", done, 0);
         check(gi, "reset err", err, 0);
         check(gi, "reset busy", busy, 0);
         check(gi, "reset req_ready", ready, 1);
         @(negedge clk); #2 rst_n = 1'b1;
         repeat (2) begin @(posedge clk); #1; end

         push(FA, FD, nw);
         acc_cyc = cyc;
         wait_idle();
         check(gi, "push to ncs fall latency", fall_cyc - acc_cyc, 2);
         check(gi, "first write reg value", periph_regs[FA], FD);

         dn0 = n_done;
         for (int i = 0; i < 6; i++) begin
            push((i == 5) ? 7'd0 : 7'(i), 8'($urandom), nw);
            if (i == 5) check(gi, "6th push held while full", nw > 0, 1);
         end
         wait_idle();
         check(gi, "done pulses for burst", n_done - dn0, 6);

         for (int i = 0; i < 24; i++) begin
            push(7'($urandom_range(0, 9)), 8'($urandom), nw);
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         end
         wait_idle();

         d = 8'($urandom);
         push(7'h05, d, nw);
         st = n_started;
         repeat (40) begin @(posedge clk); #1; end
`ifdef SPI_CFG_ADDR_CHECK_EN
         check(gi, "no frame for addr above limit", n_started - st, 0);
`else
         check(gi, "frame for addr 5", n_started - st, 1);
`endif
         wait_idle();
`ifndef SPI_CFG_ADDR_CHECK_EN
         check(gi, "reg 5 written", periph_regs[5], d);
`endif
         push(7'h04, 8'h3C, nw);
         wait_idle();
         check(gi, "reg 4 value", periph_regs[4], 8'h3C);

         for (int a = 0; a < 128; a++) snap[a] = periph_regs[a];
         push(7'd1, periph_regs[1] ^ 8'hFF, nw);
         push(7'd2, periph_regs[2] ^ 8'h5A, nw);
         push(7'd3, 8'($urandom), nw);
         n = 0;
         while (nbits < 8 && n < 2000) begin @(posedge clk); n++; end
         check(gi, "reached rising edge 8", nbits >= 8, 1);
         #2 rst_n = 1'b0;
         #1;
         check(gi, "abort ncs", ncs, 1);
         check(gi, "abort sclk", sclk, 0);
         check(gi, "abort copi", copi, 0);
         check(gi, "abort busy", busy, 0);
         check(gi, "abort done", done, 0);
         exp_q.delete();
         n_enq = 0; n_started = 0; err_pend = 0;
         repeat (3) @(posedge clk);
         @(negedge clk); #2 rst_n = 1'b1;
         repeat (60) begin @(posedge clk); #1; end
         check(gi, "queued requests lost", n_started, 0);
         bad = 0;
         for (int a = 0; a < 128; a++) if (periph_regs[a] !== snap[a]) bad++;
         check(gi, "regs unchanged by aborted frame", bad, 0);

         check(gi, "scoreboard empty", exp_q.size(), 0);
         check(gi, "all err pulses seen", err_pend, 0);
         bad = 0;
         for (int a = 0; a < 128; a++) if (periph_regs[a] !== exp_regs[a]) bad++;
         check(gi, "register file vs reference", bad, 0);
         fin = 1'b1;
      end
   end

   initial begin : summary
      int n;
      n = 0;
      while (!(g_inst[0].fin && g_inst[1].fin) && n < 80000) begin
         @(posedge clk);
         n++;
      end
      if (!(g_inst[0].fin && g_inst[1].fin)) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: instances not finished after %0d cycles", n);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_cfg_sequencer.md
# spi_cfg_sequencer

Write-only SPI controller that sequences configuration writes into the chip's SPI peripheral register bank (output enables, PWM enables, PWM duty cycle). Requesters push {address, data} pairs into a small FIFO. The block serialises each pair as one 16-bit mode-0 frame on SCLK/COPI/nCS, paced so the peripheral's 3-flop input synchronisers sample every bit. It sits on the on-chip/test side of the SPI pins and is the single owner of the bus.

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 2..255.
- CS_GAP, 8: minimum clk cycles nCS stays high between frames; legal range 1..255.
- DEPTH, 4: request FIFO entries; must be a power of two, at least 2.
- MAX_ADDR, 4: highest legal register address; used only with SPI_CFG_ADDR_CHECK_EN.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  FIFO not full; a push occurs when req_valid && req_ready at a clk edge.
- req_addr  in  7  register address.
- req_data  in  8  register data.
- busy  out  1  FIFO non-empty or state != IDLE.
- done  out  1  one-cycle pulse, asserted in the same cycle nCS returns high after a complete frame.
- err  out  1  one-cycle pulse for a rejected request; tied 0 without the macro.
- SCLK  out  1  SPI clock, idle low.
- COPI  out  1  SPI data out.
- nCS  out  1  chip select, active low.

## Operation
- Frame format: 16 bits, MSB first: bit15 = R/W = 1, bits14:8 = addr, bits7:0 = data. COPI changes only while SCLK is low; the peripheral samples on SCLK rising.
- FIFO: DEPTH entries of 15 bits, in-order.
  - Push is refused while the FIFO is full, even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle on a non-full FIFO are both honoured.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP. A divider counter div_cnt runs 0..CLK_DIV-1; a 5-bit edge counter counts SCLK edges.
- IDLE -> SETUP when the FIFO is non-empty.
  - The FIFO is popped into a 16-bit shift register.
  - nCS <= 0 and COPI <= 1 at the same edge.
- SETUP -> SHIFT after CLK_DIV cycles; the transition raises SCLK (rising edge 1).
- SHIFT: SCLK toggles every CLK_DIV cycles.
  - On each falling edge, the shift register advances and COPI takes the next bit.
  - After falling edge 16, go to HOLD; SCLK stays 0.
- HOLD -> GAP after CLK_DIV cycles: nCS <= 1 and done <= 1 for one cycle.
- GAP -> IDLE after CS_GAP cycles with nCS high.
- Reset values: nCS=1, SCLK=0, COPI=0, done=0, err=0, busy=0, req_ready=1, FIFO empty, state IDLE.
- Reset mid-frame takes effect immediately (asynchronous): nCS rises with fewer than 16 rising edges sent, so the peripheral discards the frame. No done pulse is produced, and queued requests are lost.

## Timing
- Push to nCS falling, with the FIFO empty and the FSM in IDLE: 2 clk edges (one edge to write the FIFO, one to pop).
- Rising SCLK edge k (1..16) occurs (2k-1)*CLK_DIV cycles after nCS falls.
- Falling SCLK edge k occurs 2k*CLK_DIV cycles after nCS falls.
- nCS is low for exactly 33*CLK_DIV cycles (132 at the default).
- nCS falling to the next nCS falling: at least 33*CLK_DIV + CS_GAP + 1 cycles.
- Data setup to the rising edge and hold after it are each CLK_DIV cycles, at least 2. This covers the peripheral's 3-stage synchroniser plus its edge detector.
- All outputs are registered; there are no combinational paths from inputs to SCLK, COPI or nCS.
- req_ready is derived from the registered FIFO count only.

## Configuration
- SPI_CFG_ADDR_CHECK_EN defined:
  - A request with req_addr > MAX_ADDR is still accepted (req_ready semantics unchanged) but is not enqueued.
  - err pulses for one cycle on the edge after acceptance.
  - No frame is generated for that request.
- Not defined: every address is enqueued and sent, and err is constant 0.

## Test plan
- Single write: CLK_DIV=4, addr 0x00, data 0xA5.
  - Rising-edge COPI samples are 1,0000000,10100101.
  - nCS is low for 132 cycles, with one done pulse.
  - A peripheral model shows register 0 = 0xA5.
- FIFO full:
  - Push 6 requests on consecutive cycles (addr 0..4 then 0) with DEPTH=4. req_ready deasserts after the 5th push, the 6th is held until a pop.
  - Six frames go out in push order, each pair separated by at least CS_GAP+1 nCS-high cycles.
  - busy falls only after the 6th done.
- Reset mid-frame: assert rst_n=0 after rising edge 8.
  - nCS=1, SCLK=0, COPI=0 in the same cycle; busy=0 and no done.
  - The peripheral's register values are unchanged.
- Minimum divider: CLK_DIV=2, addr 0x04, data 0x80.
  - nCS is low for 66 cycles.
  - The peripheral model's duty-cycle register = 0x80.
- Macro on:
  - addr 0x05 -> err pulse, with no nCS activity for 40 cycles.
  - addr 0x04 data 0x3C -> normal frame.
- Macro off: addr 0x05 -> full frame, done pulses, and err stays 0.
